sub_nibbles_ctrl: RTL

//  Upstream sequencer for the masked DOM SBox in the SSAES datapath. Takes the 16-bit state as two

---
 rtl/ssaes_pkg.sv | 30 +++
 rtl/sub_nibbles_ctrl_if.sv | 32 +++
 rtl/sn_tag_pipe.sv | 42 ++++
 rtl/sub_nibbles_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ssaes_pkg.sv
// Shared constants and types for the SSAES masked SubBytes sequencing logic.
// Holds widths, the fresh-randomness bit map and the sequencer FSM encoding.
package ssaes_pkg;

    localparam int NIBBLE_W = 4;
    localparam int STATE_W  = 16;
    localparam int RAND_W   = 18;
    localparam int NIBBLES  = STATE_W / NIBBLE_W;
    localparam int IDX_W    = $clog2(NIBBLES);
    localparam int CNT_W    = $clog2(NIBBLES + 1);

    // Each mask field is 2 bits wide, at these LSB offsets within rand_in/sb_rand.
    localparam int RAND_Z0  = 0;
    localparam int RAND_Z1  = 2;
    localparam int RAND_Z2  = 4;
    localparam int RAND_AZ0 = 6;
    localparam int RAND_AZ1 = 8;
    localparam int RAND_AZ2 = 10;
    localparam int RAND_BZ0 = 12;
    localparam int RAND_BZ1 = 14;
    localparam int RAND_BZ2 = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_e;

endpackage

// File: rtl/sub_nibbles_ctrl_if.sv
// Bundle of the request, randomness, SBox-side and result signals of sub_nibbles_ctrl.
// master = environment (requester + SBox), slave = the sequencer itself.
interface sub_nibbles_ctrl_if;
    import ssaes_pkg::*;

    logic                start;
    logic [STATE_W-1:0]  state_a_in;
    logic [STATE_W-1:0]  state_b_in;
    logic [RAND_W-1:0]   rand_in;
    logic                rand_valid;
    logic                rand_ready;
    logic [NIBBLE_W-1:0] sb_a;
    logic [NIBBLE_W-1:0] sb_b;
    logic [RAND_W-1:0]   sb_rand;
    logic [NIBBLE_W-1:0] sb_a_out;
    logic [NIBBLE_W-1:0] sb_b_out;
    logic [STATE_W-1:0]  state_a_out;
    logic [STATE_W-1:0]  state_b_out;
    logic                busy;
    logic                done;

    modport master (
        output start, state_a_in, state_b_in, rand_in, rand_valid, sb_a_out, sb_b_out,
        input  rand_ready, sb_a, sb_b, sb_rand, state_a_out, state_b_out, busy, done
    );

    modport slave (
        input  start, state_a_in, state_b_in, rand_in, rand_valid, sb_a_out, sb_b_out,
        output rand_ready, sb_a, sb_b, sb_rand, state_a_out, state_b_out, busy, done
    );

endinterface

// File: rtl/sn_tag_pipe.sv
// Delay line of LAT {valid, idx} tags tracking nibbles in flight through the SBox pipeline.
// Latency LAT cycles, advances every cycle; no backpressure (the SBox cannot stall).
module sn_tag_pipe #(
    parameter int LAT   = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = in_vld;
        idx_d[0] = in_idx;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/sub_nibbles_ctrl.sv
// Sequencer feeding a 2-share masked SBox one nibble per cycle and reassembling its outputs.
// Latency NIBBLES+SBOX_LAT+1 cycles start-to-done; each rand_valid=0 cycle in FEED stalls by one.
module sub_nibbles_ctrl
    import ssaes_pkg::*;
#(
    parameter int SBOX_LAT = 2
) (
    input logic               clk,
    input logic               rst_n,
    sub_nibbles_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] NIB_CNT = CNT_W'(NIBBLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    fsm_e               state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   cap_q, cap_d;
    logic [STATE_W-1:0] sh_a_q, sh_a_d;
    logic [STATE_W-1:0] sh_b_q, sh_b_d;
    logic [STATE_W-1:0] out_a_q, out_a_d;
    logic [STATE_W-1:0] out_b_q, out_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               issue;
    logic [IDX_W-1:0]   k_idx;
    logic               tag_vld;
    logic [IDX_W-1:0]   tag_idx;

    assign k_idx = k_q[IDX_W-1:0];
    assign issue = bus.rand_valid && (state_q == FEED) && (k_q < NIB_CNT);

    // Share A and share B travel on fully separate gated paths; idle cycles drive zeros.
    assign bus.rand_ready = issue;
    assign bus.sb_a       = issue ? sh_a_q[k_idx*NIBBLE_W +: NIBBLE_W] : '0;
    assign bus.sb_b       = issue ? sh_b_q[k_idx*NIBBLE_W +: NIBBLE_W] : '0;
    assign bus.sb_rand    = issue ? bus.rand_in : '0;

    sn_tag_pipe #(
        .LAT   (SBOX_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (issue),
        .in_idx  (issue ? k_idx : '0),
        .out_vld (tag_vld),
        .out_idx (tag_idx)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cap_d   = cap_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Capture runs independently of the FSM so it can overlap issue in FEED.
        if (tag_vld) begin
            out_a_d[tag_idx*NIBBLE_W +: NIBBLE_W] = bus.sb_a_out;
            out_b_d[tag_idx*NIBBLE_W +: NIBBLE_W] = bus.sb_b_out;
            cap_d = cap_q + ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FEED;
                    sh_a_d  = bus.state_a_in;
                    sh_b_d  = bus.state_b_in;
                    k_d     = '0;
                    cap_d   = '0;
                    out_a_d = '0;
                    out_b_d = '0;
                    busy_d  = 1'b1;
                end
            end
            FEED: begin
                if (issue) begin
                    k_d = k_q + ONE;
                    if (k_q == NIB_CNT - ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cap_d == NIB_CNT) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cap_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cap_q   <= cap_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.state_a_out = out_a_q;
    assign bus.state_b_out = out_b_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
